uart_tx_arbiter: RTL and testbench

Round-robin controller that shares one uart_tx serializer between NUM_REQ byte requesters. It accepts one byte per valid/ready handshake and drives the serializer's tx_start/tx_data. It sequences each frame by tracking tx_active and tx_done, so only one frame is ever in flight. It sits between the command/logging sources and the uart_tx instance.

---
 rtl/uart_arb_pkg.sv | 22 ++
 rtl/uart_arb_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the FSM state encoding and a constant clog2 for sizing.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACT  = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    // Constant-foldable ceil(log2(value)); value <= 1 yields 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching
// upward from (ptr+1) mod N. Ports: req, ptr -> winner, any_req.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_req
);

    logic found;
    int   idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        // Offsets 1..N so the last winner is considered last.
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = W'(idx);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte sources.
// Ports: clk, rst_n, req_valid/req_data/req_ready (requesters),
// tx_start/tx_data/tx_active/tx_done (serializer), busy, grant_id, tx_err.
// Optional watchdog: define UART_ARB_WATCHDOG_EN to abort stuck frames.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          NUM_REQ      = 4,
    parameter int          ID_W         = clog2(NUM_REQ),
    parameter int unsigned TIMEOUT_CLKS = 1048575
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_active,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 tx_err
);

    arb_state_t      state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic [ID_W-1:0] gid_q, gid_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] win;
    logic            any_req;

`ifdef UART_ARB_WATCHDOG_EN
    localparam int CNT_W_RAW = clog2(int'(TIMEOUT_CLKS));
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CLKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wd_fire;
`endif

    rr_pick #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .winner  (win),
        .any_req (any_req)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    data_d  = req_data[8*int'(win) +: 8];
                    gid_d   = win;
                    ptr_d   = win;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_ACT;
            end
            WAIT_ACT: begin
                if (tx_active) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
        endcase
`ifdef UART_ARB_WATCHDOG_EN
        cnt_d   = cnt_q;
        wd_fire = 1'b0;
        if (state_q == LAUNCH) begin
            cnt_d = '0;
        end else if (state_q == WAIT_ACT || state_q == WAIT_DONE) begin
            // Abort overrides a normal completion; pointer stays advanced.
            if (cnt_q == WD_LIMIT) begin
                wd_fire = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            gid_q   <= '0;
            ptr_q   <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef UART_ARB_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tx_err = wd_fire;
`else
    assign tx_err = 1'b0;
`endif

    // Acceptance and start are the LAUNCH cycle itself.
    always_comb begin
        req_ready = '0;
        if (state_q == LAUNCH) begin
            req_ready[gid_q] = 1'b1;
        end
    end

    assign tx_start = (state_q == LAUNCH);
    assign busy     = (state_q != IDLE);
    assign tx_data  = data_q;
    assign grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx stub.
// Table of grant rounds plus hand sequences for mid-frame and reset cases.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_active;
    logic        tx_done;
    logic        busy;
    logic [1:0]  grant_id;
    logic        tx_err;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int done_cyc = 0;
    int ready_cnt = 0;
    logic [7:0] rx_last = 8'h00;

    localparam int EXP_GRANTS = 17;

    typedef struct {
        logic [3:0]  add;
        logic [31:0] data;
        logic [1:0]  gid;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vt [12];

    uart_tx_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .busy      (busy),
        .grant_id  (grant_id),
        .tx_err    (tx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) ready_cnt <= ready_cnt + $countones(req_ready);

    // uart_tx stub: 8 bit cycles LSB first, then a tx_done pulse.
    initial begin
        logic [7:0] rx;
        bit         abort;
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_start === 1'b1) begin
                abort     = 1'b0;
                rx        = 8'h00;
                tx_active = 1'b1;
                for (int b = 0; b < 8; b++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                    rx = {tx_data[b], rx[7:1]};
                end
                if (!abort) begin
                    rx_last  = rx;
                    done_cyc = cyc_cnt;
                    tx_done  = 1'b1;
                    @(negedge clk);
                end
                tx_done   = 1'b0;
                tx_active = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (tx_start !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("start_seen", 32'(tx_start), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_seen", 32'(busy), 0);
    endtask

    initial begin
        logic [3:0] pending;
        int         cyc;
        int         spurious;
        int         n;

        vt[0]  = '{4'b0001, 32'h131211A5, 2'd0, 8'hA5};
        vt[1]  = '{4'b1111, 32'h13121110, 2'd1, 8'h11};
        vt[2]  = '{4'b0000, 32'h13121110, 2'd2, 8'h12};
        vt[3]  = '{4'b0000, 32'h13121110, 2'd3, 8'h13};
        vt[4]  = '{4'b0000, 32'h13121110, 2'd0, 8'h10};
        vt[5]  = '{4'b0100, 32'h13121110, 2'd2, 8'h12};
        vt[6]  = '{4'b1001, 32'h13121110, 2'd3, 8'h13};
        vt[7]  = '{4'b0000, 32'h13121110, 2'd0, 8'h10};
        vt[8]  = '{4'b0010, 32'h13121110, 2'd1, 8'h11};
        vt[9]  = '{4'b0010, 32'h13121110, 2'd1, 8'h11};
        vt[10] = '{4'b1000, 32'h13121110, 2'd3, 8'h13};
        vt[11] = '{4'b0001, 32'h13121110, 2'd0, 8'h10};

        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_tx_err", 32'(tx_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        pending = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            pending   = pending | vt[i].add;
            req_valid = pending;
            req_data  = vt[i].data;
            wait_start(cyc);
            if (i == 0) check("latency", 32'(cyc), 1);
            check($sformatf("v%0d_gid", i), 32'(grant_id), 32'(vt[i].gid));
            check($sformatf("v%0d_data", i), 32'(tx_data),
                  32'(vt[i].exp_byte));
            check($sformatf("v%0d_ready", i), 32'(req_ready),
                  32'(4'b0001 << vt[i].gid));
            pending   = pending & ~(4'b0001 << vt[i].gid);
            req_valid = pending;
            wait_idle();
            check($sformatf("v%0d_line", i), 32'(rx_last),
                  32'(vt[i].exp_byte));
        end

        // Valid rising mid-frame waits for tx_done, then 2-cycle gap.
        req_valid = 4'b0001;
        req_data  = 32'h13121110;
        wait_start(cyc);
        check("mid_gid0", 32'(grant_id), 0);
        req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        req_valid = 4'b0010;
        req_data  = 32'h13125C10;
        spurious  = 0;
        n         = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
            if (tx_start === 1'b1) spurious++;
        end
        check("mid_no_start", 32'(spurious), 0);
        wait_start(cyc);
        check("mid_gap", 32'(cyc_cnt - done_cyc), 2);
        check("mid_gid1", 32'(grant_id), 1);
        check("mid_data", 32'(tx_data), 32'h5C);
        req_valid = 4'b0000;
        wait_idle();
        check("mid_line", 32'(rx_last), 32'h5C);

        // Reset during WAIT_DONE, pending requests restart from 0.
        req_valid = 4'b0100;
        req_data  = 32'h13121110;
        wait_start(cyc);
        check("rf_gid2", 32'(grant_id), 2);
        req_valid = 4'b0000;
        repeat (4) @(negedge clk);
        check("rf_busy", 32'(busy), 1);
        req_valid = 4'b1010;
        #2 rst_n = 1'b0;
        #1;
        check("rf_busy0", 32'(busy), 0);
        check("rf_start0", 32'(tx_start), 0);
        check("rf_ready0", 32'(req_ready), 0);
        check("rf_data0", 32'(tx_data), 0);
        check("rf_gid0", 32'(grant_id), 0);
        check("rf_err0", 32'(tx_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_start(cyc);
        check("rf_next_gid", 32'(grant_id), 1);
        check("rf_next_data", 32'(tx_data), 32'h11);
        req_valid = 4'b1000;
        wait_idle();
        wait_start(cyc);
        check("rf_then_gid", 32'(grant_id), 3);
        check("rf_then_data", 32'(tx_data), 32'h13);
        req_valid = 4'b0000;
        wait_idle();
        check("rf_then_line", 32'(rx_last), 32'h13);

        @(negedge clk);
        check("ready_pulses", 32'(ready_cnt), EXP_GRANTS);
        check("err_idle", 32'(tx_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
